// File: rtl/serial_out.sv
// serial_out: 8N1 LSB-first serial transmitter fed by a byte FIFO.
// Define SERIAL_OUT_CTS_EN to gate frame starts on a synchronized cts_n.
module serial_out #(
  parameter int CLK_FREQUENCY_HZ = 108_000_000,
  parameter int SERIAL_BPS = 3_000_000,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       ie,
  output logic       ready,
  output logic       busy,
  output logic       overflow,
  input  logic       cts_n,
  output logic       tx
);
  localparam int BIT_CYCLES = CLK_FREQUENCY_HZ / SERIAL_BPS;
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int AW = FIFO_DEPTH_LOG2;
  if (BIT_CYCLES < 4) begin : g_bit_cycles_check
    $error("serial_out: BIT_CYCLES must be >= 4");
  end
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic [7:0] mem [1<<AW];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic tx_n, pop, wr, empty, last, start, can_start;
`ifdef SERIAL_OUT_CTS_EN
  logic [1:0] cts_sync;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cts_sync <= 2'b11;
    else cts_sync <= {cts_sync[0], cts_n};
  assign can_start = ~cts_sync[1];
`else
  logic unused_cts;
  assign unused_cts = cts_n;
  assign can_start = 1'b1;
`endif
  assign empty = wr_ptr == rd_ptr;
  assign wr = ie & ready;
  assign overflow = ie & ~ready;
  assign busy = ~empty | (state != IDLE);
  assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, wr};
  assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};
  assign last = cnt == CW'(BIT_CYCLES - 1);
  assign start = ~empty & can_start;
  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      ready <= !((wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]));
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr[AW-1:0]] <= data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= tx_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    pop = 1'b0;
    tx_n = 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          pop = 1'b1;
          shift_n = mem[rd_ptr[AW-1:0]];
          idx_n = '0;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (last) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (last) begin
          cnt_n = '0;
          shift_n = {1'b0, shift[7:1]};
          idx_n = idx + 1'b1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      default: begin
        if (last) begin
          cnt_n = '0;
          state_n = IDLE;
          if (start) begin
            pop = 1'b1;
            shift_n = mem[rd_ptr[AW-1:0]];
            idx_n = '0;
            state_n = START;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_serial_out.sv
// tb_serial_out: directed vector bench for serial_out (default and 4-cycle-bit instances).
module tb_serial_out;
  logic clk = 0, reset_n = 0, ie = 0, ie_s = 0, cts_n = 0;
  logic [7:0] data = 0, data_s = 0;
  logic ready, busy, overflow, tx, ready_s, busy_s, overflow_s, tx_s;
  int checks = 0, failures = 0, rst_events = 0, mon_bad = 0, mon_r0 = 0, dummy = 0;
  logic bz_a, bz_b, mon_good;
  logic [7:0] mon_b;
  logic [7:0] mon_q[$];
  typedef struct { int sel; logic [7:0] d; logic cts; } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  serial_out dut (
    .clk(clk), .reset_n(reset_n), .data(data), .ie(ie), .ready(ready), .busy(busy),
    .overflow(overflow), .cts_n(cts_n), .tx(tx)
  );
  serial_out #(.CLK_FREQUENCY_HZ(100), .SERIAL_BPS(25)) dut_s (
    .clk(clk), .reset_n(reset_n), .data(data_s), .ie(ie_s), .ready(ready_s), .busy(busy_s),
    .overflow(overflow_s), .cts_n(cts_n), .tx(tx_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic txv(input int sel);
    return sel != 0 ? tx_s : tx;
  endfunction

  function automatic logic busyv(input int sel);
    return sel != 0 ? busy_s : busy;
  endfunction

  task automatic write_byte(input int sel, input logic [7:0] d);
    @(negedge clk);
    if (sel != 0) begin ie_s = 1; data_s = d; end
    else begin ie = 1; data = d; end
    @(negedge clk);
    ie = 0;
    ie_s = 0;
  endtask

  // Checks every clock of one frame against the ideal 10-symbol waveform.
  task automatic check_frame(input int sel, input logic [7:0] b, input bit contig,
                             input string nm, output int waited);
    int bc;
    int err;
    logic [9:0] sym;
    bc = sel != 0 ? 4 : 36;
    err = 0;
    waited = 0;
    sym = {1'b1, b, 1'b0};
    if (contig) @(negedge clk);
    else
      while (txv(sel) !== 1'b0 && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
    chk({nm, "_start"}, {31'd0, txv(sel)}, 32'd0);
    for (int k = 0; k < 10 * bc; k++) begin
      if (k > 0) @(negedge clk);
      if (txv(sel) !== sym[k / bc]) err++;
      if (k == 10 * bc - 2) bz_a = busyv(sel);
      if (k == 10 * bc - 1) bz_b = busyv(sel);
    end
    chk({nm, "_bit_errors"}, err, 0);
  endtask

  always @(negedge reset_n) rst_events++;

  // Mid-bit sampling receiver on the default-rate line; frames cut by reset are dropped.
  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1 && tx === 1'b0) begin
      mon_r0 = rst_events;
      repeat (18) @(negedge clk);
      mon_good = tx === 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (36) @(negedge clk);
        mon_b[i] = tx;
      end
      repeat (36) @(negedge clk);
      mon_good = mon_good && tx === 1'b1;
      if (rst_events == mon_r0) begin
        mon_q.push_back(mon_b);
        if (!mon_good) mon_bad++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int t, err;
    vecs[0] = '{0, 8'h55, 1'b0};
    vecs[1] = '{1, 8'hA5, 1'b0};
    vecs[2] = '{0, 8'h81, 1'b1};
    vecs[3] = '{1, 8'h3C, 1'b0};
    vecs[4] = '{0, 8'hC6, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_tx_s", {31'd0, tx_s}, 32'd1);
    chk("rst_ready_s", {31'd0, ready_s}, 32'd1);
    reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
`ifndef SERIAL_OUT_CTS_EN
      cts_n = vecs[i].cts;
`endif
      write_byte(vecs[i].sel, vecs[i].d);
      @(negedge clk);
      chk($sformatf("v%0d_latency_tx_high", i), {31'd0, txv(vecs[i].sel)}, 32'd1);
      chk($sformatf("v%0d_busy_queued", i), {31'd0, busyv(vecs[i].sel)}, 32'd1);
      check_frame(vecs[i].sel, vecs[i].d, 1'b1, $sformatf("v%0d", i), dummy);
      chk($sformatf("v%0d_busy_late", i), {31'd0, bz_a}, 32'd1);
      chk($sformatf("v%0d_busy_fall", i), {31'd0, bz_b}, 32'd0);
      cts_n = 0;
      repeat (5) @(negedge clk);
    end

    @(negedge clk); ie = 1; data = 8'h00;
    @(negedge clk); data = 8'hFF;
    @(negedge clk); ie = 0;
    check_frame(0, 8'h00, 1'b1, "b2b_first", dummy);
    chk("b2b_busy_between", {31'd0, bz_b}, 32'd1);
    check_frame(0, 8'hFF, 1'b1, "b2b_second", dummy);
    chk("b2b_busy_fall", {31'd0, bz_b}, 32'd0);
    repeat (5) @(negedge clk);

    mon_q.delete();
    mon_bad = 0;
    err = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (ready !== 1'b1) err++;
      ie = 1;
      data = 8'(i * 37 + 5);
    end
    chk("fill_ready_errors", err, 0);
    @(negedge clk);
    data = 8'hEE;
    #1;
    chk("full_ready", {31'd0, ready}, 32'd0);
    chk("full_overflow", {31'd0, overflow}, 32'd1);
    @(negedge clk);
    ie = 0;
    #1;
    chk("overflow_single", {31'd0, overflow}, 32'd0);
    t = 0;
    while (mon_q.size() < 17 && t < 8000) begin @(negedge clk); t++; end
    chk("fill_frames", mon_q.size(), 17);
    for (int i = 0; i < 17 && i < mon_q.size(); i++)
      chk($sformatf("fill_byte%0d", i), {24'd0, mon_q[i]}, {24'd0, 8'(i * 37 + 5)});
    repeat (400) @(negedge clk);
    chk("fill_no_extra", mon_q.size(), 17);
    chk("fill_framing", mon_bad, 0);
    chk("fill_idle_busy", {31'd0, busy}, 32'd0);
    chk("fill_idle_ready", {31'd0, ready}, 32'd1);

    mon_q.delete();
    @(negedge clk); ie = 1; data = 8'h30;
    @(negedge clk); data = 8'h99;
    @(negedge clk); ie = 0;
    repeat (1 + 4 * 36 + 10) @(negedge clk);
    chk("mid_bit3_low", {31'd0, tx}, 32'd0);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1;
    err = 0;
    repeat (800) begin
      @(negedge clk);
      if (tx !== 1'b1) err++;
    end
    chk("post_rst_tx_idle", err, 0);
    chk("post_rst_frames", mon_q.size(), 0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);

`ifdef SERIAL_OUT_CTS_EN
    cts_n = 1;
    repeat (3) @(negedge clk);
    write_byte(0, 8'h41);
    err = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) err++;
    end
    chk("cts_hold_tx", err, 0);
    chk("cts_hold_busy", {31'd0, busy}, 32'd1);
    cts_n = 0;
    fork
      begin repeat (100) @(negedge clk); cts_n = 1; end
    join_none
    check_frame(0, 8'h41, 1'b0, "cts_frame", t);
    chk("cts_latency_ok", {31'd0, t >= 2 && t <= 4}, 32'd1);
    repeat (5) @(negedge clk);
    chk("cts_done_busy", {31'd0, busy}, 32'd0);
    cts_n = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
